mdio_arbiter: RTL
=================

// Module: mdio_arbiter
// PURPOSE
//  Shares one shift_mdio serial engine between N_REQ command sources (host passthrough,
//  link-poll FSM, init sequencer). Round-robin grant, one 32-bit MDIO frame per grant,
//  strobe/done handshake towards the engine, per-requester response pulse, hang timeout.
//  Sits between the PHY management FSMs and a single shift_mdio instance.
// PARAMETERS
//  N_REQ           3        number of requesters, 1..4
//  TIMEOUT_CYCLES  200000   max clk cycles per handshake phase before error abort
// PORTS
//  clk          in   1          system clock, all logic on posedge
//  rst          in   1          synchronous, active-low reset (0 = reset)
//  req_valid    in   N_REQ      requester i has a command pending; hold until req_ack[i]
//  req_cmd      in   32*N_REQ   frame for requester i at [32*i+31:32*i], shift_mdio format
//  req_ack      out  N_REQ      1-cycle pulse: command i accepted, may be dropped
//  rsp_valid    out  N_REQ      1-cycle pulse: command i finished
//  rsp_data     out  16         read data (0 for writes), valid with rsp_valid
//  rsp_err      out  1          timeout or illegal opcode, valid with rsp_valid
//  eng_en       out  1          engine start strobe (shift_mdio eni)
//  eng_wdata    out  32         engine frame (shift_mdio wdatai)
//  eng_rd_done  in   1          shift_mdio rd_doneo (low while read busy)
//  eng_wr_done  in   1          shift_mdio wr_doneo (low while write busy)
//  eng_rdata    in   16         shift_mdio rdatao
//  busy         out  1          1 in any state except S_IDLE
//  owner        out  2          index of current/last granted requester
// BEHAVIOUR
//  Reset (rst=0 at posedge): state S_IDLE; req_ack, rsp_valid, eng_en, rsp_err, busy = 0;
//   rsp_data=0; eng_wdata=0; owner=N_REQ-1 (so first search starts at requester 0); timer=0.
//  Opcode = cmd[29:28]: 2'b10 read (tracks eng_rd_done), 2'b01 write (tracks eng_wr_done),
//   other values illegal. All outputs registered.
//  S_IDLE: if any req_valid: winner = first set bit scanning owner+1, owner+2, ... mod N_REQ.
//   Next edge: req_ack[winner]=1, owner=winner, eng_wdata=cmd, busy=1;
//   legal opcode -> eng_en=1, S_STRB; illegal -> S_RESP with err=1, engine untouched.
//  S_STRB: hold eng_en=1 until selected done input reads 0, then eng_en=0, timer=0, S_WAIT.
//  S_WAIT: wait for selected done=1; latch rsp_data = read ? eng_rdata : 0, err=0, S_RESP.
//  Timeout: timer increments in S_STRB/S_WAIT, cleared on entry to each; at TIMEOUT_CYCLES
//   -> eng_en=0, rsp_data=16'hFFFF, err=1, S_RESP.
//  S_RESP: rsp_valid[owner]=1 one cycle with rsp_data/rsp_err; -> S_IDLE. rsp_data/rsp_err
//   hold until next response.
//  Latency: req_valid seen in S_IDLE at edge t -> req_ack/eng_en at t+1; rsp_valid 1 cycle
//   after the done rising edge is sampled. Min gap between grants: 1 S_IDLE cycle.
//  req_valid dropping before req_ack: no effect on arbitration already performed.
//  req_valid of other requesters during a transaction: queued, served per round-robin.
//  Simultaneous requests: strictly rotating; no requester waits more than N_REQ-1 grants.
//  Reset mid-frame: abort to S_IDLE, no rsp_valid; engine resets through its own rst.
//  eng_en is never high outside S_STRB; at most one frame outstanding on the engine.
// TESTING
//  1 Single read req 0, cmd=32'h6002_0000 (reg 0); engine model rd_done low 40 cycles,
//    rdata=16'h1140 -> ack[0] at t+1, one rsp_valid[0], rsp_data=16'h1140, rsp_err=0.
//  2 req_valid=3'b111 held continuously, 6 writes each -> grant order 0,1,2,0,1,2,...;
//    each ack count = 6, rsp_data=0 on every response.
//  3 Engine rd_done stuck high, TIMEOUT_CYCLES=100 -> eng_en falls after 100 cycles,
//    rsp_valid with rsp_err=1, rsp_data=16'hFFFF; next request served normally.
//  4 cmd[29:28]=2'b11 on req 1 -> ack[1], rsp_valid[1] 1 cycle later, rsp_err=1,
//    eng_en never asserted.
//  5 rst=0 for one cycle during S_WAIT -> busy=0, eng_en=0, no rsp_valid, owner=N_REQ-1;
//    a request after release is granted normally.
//  6 req 2 asserted while req 0 transaction in flight -> req 2 granted immediately
//    after rsp_valid[0], with exactly one S_IDLE cycle between.

Source files
------------

// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin sharing of one shift_mdio engine between N_REQ
// command sources, one 32-bit frame per grant, with a per-phase hang timeout.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   req_valid/req_cmd        per-requester pending flag and 32-bit frame
//   req_ack/rsp_valid        per-requester accept / completion pulses
//   rsp_data/rsp_err         response payload, held until the next response
//   eng_en/eng_wdata         engine start strobe and frame
//   eng_rd_done/eng_wr_done  engine done levels (low while busy)
//   eng_rdata                engine read data
//   busy/owner               arbiter activity and current/last grantee
module mdio_arbiter #(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [32*N_REQ-1:0] req_cmd,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [15:0]        rsp_data,
    output logic               rsp_err,
    output logic               eng_en,
    output logic [31:0]        eng_wdata,
    input  logic               eng_rd_done,
    input  logic               eng_wr_done,
    input  logic [15:0]        eng_rdata,
    output logic               busy,
    output logic [1:0]         owner
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STRB,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   rspv_q, rspv_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               en_q, en_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               busy_q, busy_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               is_rd_q, is_rd_d;

    // Requests and commands widened to the 4-slot maximum so that
    // the 2-bit owner index is always in range.
    logic [3:0]         vld4;
    logic [3:0][31:0]   cmd_arr;
    logic [2:0]         scan;
    logic               win_found;
    logic [1:0]         win_idx;
    logic [31:0]        cmd_sel;
    logic [1:0]         op;
    logic               legal;
    logic               done_sel;
    logic [3:0]         win_oh;
    logic [3:0]         own_oh;
    logic               tmo;

    assign vld4 = 4'(req_valid);

    for (genvar g = 0; g < 4; g++) begin : g_cmd
        if (g < N_REQ) begin : g_on
            assign cmd_arr[g] = req_cmd[32*g +: 32];
        end else begin : g_off
            assign cmd_arr[g] = '0;
        end
    end

    // Round-robin: first pending requester after the last grantee.
    always_comb begin
        win_found = 1'b0;
        win_idx   = owner_q;
        scan      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan = {1'b0, owner_q} + 3'(k);
            if (scan >= 3'(N_REQ)) begin
                scan = scan - 3'(N_REQ);
            end
            if (!win_found && vld4[scan[1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[1:0];
            end
        end
    end

    assign cmd_sel  = cmd_arr[win_idx];
    assign op       = cmd_sel[29:28];
    assign legal    = (op == 2'b10) || (op == 2'b01);
    assign done_sel = is_rd_q ? eng_rd_done : eng_wr_done;
    assign win_oh   = 4'b0001 << win_idx;
    assign own_oh   = 4'b0001 << owner_q;
    assign tmo      = (timer_q == T_LAST);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ack_d   = '0;
        rspv_d  = '0;
        rdata_d = rdata_q;
        err_d   = err_q;
        en_d    = en_q;
        wdata_d = wdata_q;
        timer_d = timer_q;
        is_rd_d = is_rd_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    ack_d   = win_oh[N_REQ-1:0];
                    owner_d = win_idx;
                    wdata_d = cmd_sel;
                    is_rd_d = (op == 2'b10);
                    if (legal) begin
                        en_d    = 1'b1;
                        timer_d = '0;
                        state_d = S_STRB;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_STRB: begin
                // Engine has taken the frame once its done level drops.
                if (!done_sel) begin
                    en_d    = 1'b0;
                    timer_d = '0;
                    state_d = S_WAIT;
                end else if (tmo) begin
                    en_d    = 1'b0;
                    rdata_d = 16'hFFFF;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (done_sel) begin
                    rdata_d = is_rd_q ? eng_rdata : 16'h0000;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (tmo) begin
                    rdata_d = 16'hFFFF;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                rspv_d  = own_oh[N_REQ-1:0];
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= 2'(N_REQ - 1);
            ack_q   <= '0;
            rspv_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            timer_q <= '0;
            is_rd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
            rspv_q  <= rspv_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            en_q    <= en_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            timer_q <= timer_d;
            is_rd_q <= is_rd_d;
        end
    end

    assign req_ack   = ack_q;
    assign rsp_valid = rspv_q;
    assign rsp_data  = rdata_q;
    assign rsp_err   = err_q;
    assign eng_en    = en_q;
    assign eng_wdata = wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule
